// File: rtl/ahb_top_system.sv
// rtl/ahb_top_system.sv - AHB-Lite subsystem: request bridge, decoder, three memory slaves, default slave
module ahb_top_system #(
  parameter int MEM_DEPTH  = 256,
  parameter int NUM_SLAVES = 3
) (
  input  logic        clk,
  input  logic        hresetn,
  input  logic        enable,
  input  logic [31:0] in_hwdata,
  input  logic [31:0] in_haddr,
  input  logic [2:0]  in_hsize,
  input  logic [2:0]  in_hburst,
  input  logic [1:0]  in_hsel,
  input  logic        in_hwrite,
  input  logic [1:0]  in_htrans,
  output logic [31:0] out_hrdata
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  // Address-phase registers owned by the master
  logic [31:0] m_haddr;
  logic        m_hwrite;
  logic [2:0]  m_hsize;
  logic [2:0]  m_hburst;
  logic [1:0]  m_hsel;
  htrans_t     m_htrans;
  logic [31:0] m_hwdata;

  // Data-phase control latched by the decoder and slaves
  logic             d_active;
  logic             d_write;
  logic [2:0]       d_size;
  logic [1:0]       d_lane;
  logic [1:0]       d_sel;
  logic [IDX_W-1:0] d_idx;

  logic [31:0] mem [NUM_SLAVES][MEM_DEPTH];

  logic        dflt_sel;
  logic        hresp_err;
  logic        mem_wr;
  logic [3:0]  wr_strb;
  logic [31:0] rdata_mux;

  // Byte lanes touched by a transfer; unaligned sizes fall back to the aligned lane rule
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      3'd0:    lane_mask = 4'b0001 << lane;
      3'd1:    lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Master: capture request fields at the address edge, write data one edge later
  always_ff @(posedge clk) begin
    if (hresetn) begin
      m_haddr  <= '0;
      m_hwrite <= 1'b0;
      m_hsize  <= '0;
      m_hburst <= '0;
      m_hsel   <= '0;
      m_htrans <= HTRANS_IDLE;
      m_hwdata <= '0;
    end else begin
      m_haddr  <= in_haddr;
      m_hwrite <= in_hwrite;
      m_hsize  <= in_hsize;
      m_hburst <= in_hburst;
      m_hsel   <= in_hsel;
      m_htrans <= enable ? htrans_t'(in_htrans) : HTRANS_IDLE;
      m_hwdata <= in_hwdata;
    end
  end

  // Decoder/slaves: latch address-phase control at the start of the data phase
  always_ff @(posedge clk) begin
    if (hresetn) begin
      d_active <= 1'b0;
      d_write  <= 1'b0;
      d_size   <= '0;
      d_lane   <= '0;
      d_sel    <= '0;
      d_idx    <= '0;
    end else begin
      d_active <= (m_htrans == HTRANS_NONSEQ) || (m_htrans == HTRANS_SEQ);
      d_write  <= m_hwrite;
      d_size   <= m_hsize;
      d_lane   <= m_haddr[1:0];
      d_sel    <= m_hsel;
      d_idx    <= m_haddr[IDX_W+1:2];
    end
  end

  // Default slave answers ERROR to real transfers; erroring transfers never touch memory
  always_comb begin
    dflt_sel  = (32'(d_sel) >= NUM_SLAVES);
    hresp_err = d_active && dflt_sel;
    mem_wr    = d_active && d_write && !hresp_err;
    wr_strb   = lane_mask(d_size, d_lane);
    rdata_mux = '0;
    if (!dflt_sel) begin
      rdata_mux = mem[d_sel][d_idx];
    end
  end

  // Slave memories: cleared on reset, byte-lane writes committed at the end of the data phase
  always_ff @(posedge clk) begin
    if (hresetn) begin
      for (int s = 0; s < NUM_SLAVES; s++) begin
        for (int w = 0; w < MEM_DEPTH; w++) begin
          mem[s][w] <= '0;
        end
      end
    end else if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) begin
          mem[d_sel][d_idx][8*b +: 8] <= m_hwdata[8*b +: 8];
        end
      end
    end
  end

  // Read data register: updates only when a read transfer completes
  always_ff @(posedge clk) begin
    if (hresetn) begin
      out_hrdata <= '0;
    end else if (d_active && !d_write) begin
      out_hrdata <= rdata_mux;
    end
  end

  // Burst type and high address bits are carried on the bus but do not steer anything
  logic unused_ok;
  assign unused_ok = ^{m_hburst, m_haddr[31:IDX_W+2]};

endmodule

// File: tb/tb_ahb_top_system.sv
// tb/tb_ahb_top_system.sv - directed self-checking bench for ahb_top_system
module tb_ahb_top_system;

  logic        clk;
  logic        hresetn;
  logic        enable;
  logic [31:0] in_hwdata;
  logic [31:0] in_haddr;
  logic [2:0]  in_hsize;
  logic [2:0]  in_hburst;
  logic [1:0]  in_hsel;
  logic        in_hwrite;
  logic [1:0]  in_htrans;
  logic [31:0] out_hrdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  ahb_top_system #(.MEM_DEPTH(256), .NUM_SLAVES(3)) dut (
    .clk        (clk),
    .hresetn    (hresetn),
    .enable     (enable),
    .in_hwdata  (in_hwdata),
    .in_haddr   (in_haddr),
    .in_hsize   (in_hsize),
    .in_hburst  (in_hburst),
    .in_hsel    (in_hsel),
    .in_hwrite  (in_hwrite),
    .in_htrans  (in_htrans),
    .out_hrdata (out_hrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic go_idle();
    enable    = 1'b1;
    in_htrans = T_IDLE;
    in_hwrite = 1'b0;
  endtask

  task automatic do_write(input logic en, input logic [1:0] trans, input logic [1:0] sel,
                          input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    enable    = en;
    in_htrans = trans;
    in_hwrite = 1'b1;
    in_hsel   = sel;
    in_haddr  = addr;
    in_hsize  = size;
    in_hburst = 3'd0;
    tick();
    go_idle();
    in_hwdata = data;
    tick();
    in_hwdata = 32'h0;
    tick();
  endtask

  task automatic do_read(input logic [1:0] trans, input logic [1:0] sel,
                         input logic [31:0] addr, output logic [31:0] data);
    enable    = 1'b1;
    in_htrans = trans;
    in_hwrite = 1'b0;
    in_hsel   = sel;
    in_haddr  = addr;
    in_hsize  = 3'd2;
    in_hburst = 3'd0;
    tick();
    go_idle();
    tick();
    tick();
    data = out_hrdata;
  endtask

  initial begin
    hresetn   = 1'b1;
    enable    = 1'b0;
    in_hwdata = 32'h0;
    in_haddr  = 32'h0;
    in_hsize  = 3'd2;
    in_hburst = 3'd0;
    in_hsel   = 2'd0;
    in_hwrite = 1'b0;
    in_htrans = T_IDLE;
    tick();
    tick();
    hresetn = 1'b0;
    go_idle();
    tick();

    check("reset_hrdata", out_hrdata, 32'h0);
    do_read(T_NONSEQ, 2'd0, 32'h0, rd);
    check("reset_read_s0_a0", rd, 32'h0);

    // Back-to-back write then read of the same word
    enable = 1'b1; in_htrans = T_NONSEQ; in_hwrite = 1'b1; in_hsel = 2'd0;
    in_haddr = 32'h4; in_hsize = 3'd2; in_hburst = 3'd1;
    tick();
    in_hwdata = 32'hDEADBEEF; in_hwrite = 1'b0; in_haddr = 32'h4;
    tick();
    go_idle(); in_hwdata = 32'h0;
    tick();
    check("b2b_one_edge", out_hrdata, 32'h0);
    tick();
    check("b2b_two_edges", out_hrdata, 32'hDEADBEEF);

    // Byte and halfword lanes
    do_write(1'b1, T_NONSEQ, 2'd0, 32'h0, 3'd2, 32'h0);
    do_write(1'b1, T_NONSEQ, 2'd0, 32'h1, 3'd0, 32'h0000AB00);
    do_read(T_NONSEQ, 2'd0, 32'h0, rd);
    check("byte_lane1", rd, 32'h0000AB00);
    do_write(1'b1, T_NONSEQ, 2'd0, 32'h2, 3'd1, 32'h12340000);
    do_read(T_NONSEQ, 2'd0, 32'h0, rd);
    check("half_upper", rd, 32'h1234AB00);

    // Word write ignores addr[1:0]; index 257 aliases to index 1
    do_write(1'b1, T_NONSEQ, 2'd0, 32'h406, 3'd2, 32'hCAFEF00D);
    do_read(T_NONSEQ, 2'd0, 32'h4, rd);
    check("wrap_word", rd, 32'hCAFEF00D);

    // Slave isolation
    do_write(1'b1, T_NONSEQ, 2'd0, 32'h8, 3'd2, 32'h11);
    do_write(1'b1, T_NONSEQ, 2'd2, 32'h8, 3'd2, 32'h22);
    do_read(T_NONSEQ, 2'd0, 32'h8, rd);
    check("iso_s0", rd, 32'h11);
    do_read(T_NONSEQ, 2'd2, 32'h8, rd);
    check("iso_s2", rd, 32'h22);
    do_read(T_NONSEQ, 2'd1, 32'h8, rd);
    check("iso_s1", rd, 32'h0);

    // Qualifiers: no memory access and no read-data update
    do_read(T_NONSEQ, 2'd0, 32'h8, rd);
    check("qual_pre", rd, 32'h11);
    do_write(1'b0, T_NONSEQ, 2'd0, 32'h8, 3'd2, 32'h55);
    check("qual_en0_hold", out_hrdata, 32'h11);
    do_write(1'b1, T_IDLE, 2'd0, 32'h8, 3'd2, 32'h55);
    check("qual_idle_hold", out_hrdata, 32'h11);
    do_write(1'b1, T_BUSY, 2'd0, 32'h8, 3'd2, 32'h55);
    check("qual_busy_hold", out_hrdata, 32'h11);
    do_read(T_BUSY, 2'd2, 32'h8, rd);
    check("qual_busy_read", rd, 32'h11);
    do_write(1'b1, T_NONSEQ, 2'd3, 32'h8, 3'd2, 32'h55);
    do_read(T_NONSEQ, 2'd3, 32'h8, rd);
    check("dflt_read", rd, 32'h0);
    do_read(T_NONSEQ, 2'd0, 32'h8, rd);
    check("qual_mem_kept", rd, 32'h11);

    // Reset lands on the commit edge of a write
    enable = 1'b1; in_htrans = T_NONSEQ; in_hwrite = 1'b1; in_hsel = 2'd1;
    in_haddr = 32'hC; in_hsize = 3'd2;
    tick();
    go_idle(); in_hwdata = 32'h99;
    tick();
    hresetn = 1'b1; in_hwdata = 32'h0;
    tick();
    check("rst_mid_hrdata", out_hrdata, 32'h0);
    hresetn = 1'b0;
    tick();
    do_read(T_NONSEQ, 2'd1, 32'hC, rd);
    check("rst_mid_word", rd, 32'h0);
    do_read(T_NONSEQ, 2'd0, 32'h8, rd);
    check("rst_cleared_s0", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_top_system.md
Name: ahb_top_system

Overview:
- Self-contained AHB-Lite subsystem: one master bridges a simple request interface onto an internal AHB bus.
- The bus runs through an address decoder to three zero-wait-state memory slaves plus a default slave, with a read-data multiplexer back to the master.
- Used as the top-level block for system-level AHB verification; the only externally visible result is read data on out_hrdata.

Parameters:
- MEM_DEPTH, 256, number of 32-bit words per slave memory; word index = haddr[log2(MEM_DEPTH)+1:2].
- NUM_SLAVES, 3, number of memory slaves; in_hsel values >= NUM_SLAVES select the default slave.

Ports:
- clk, input, 1, single system clock; all logic on rising edge.
- hresetn, input, 1, synchronous active-high reset, sampled on rising clk.
- enable, input, 1, request qualifier; 0 forces the bus to IDLE.
- in_hwdata, input, 32, write data; sampled one cycle after its address.
- in_haddr, input, 32, byte address.
- in_hsize, input, 3, 0=byte, 1=halfword, 2=word; other values treated as word.
- in_hburst, input, 3, burst type; forwarded on the bus, informational only.
- in_hsel, input, 2, slave select: 0..2 = memory slaves, 3 = default slave.
- in_hwrite, input, 1, 1=write, 0=read.
- in_htrans, input, 2, IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- out_hrdata, output, 32, registered read data of the last completed read.

Behaviour:
- Reset (hresetn=1 at a rising edge):
  - All pipeline registers cleared; bus htrans=IDLE.
  - out_hrdata=0.
  - All slave memory words cleared to 0.
  - Reset mid-transfer abandons it; no write is committed at that edge.
- Address phase:
  - At rising edge k, with enable=1, the master registers in_haddr, in_hwrite, in_hsize, in_hburst, in_hsel, in_htrans.
  - With enable=0, the registered htrans is IDLE; other fields are don't-care.
- Data phase:
  - At edge k+1 the decoder and slaves latch the address-phase control; data phase spans k+1..k+2.
  - At edge k+1 the master also registers in_hwdata, so write data must be valid one cycle after its address.
- Transfer qualification:
  - Only NONSEQ and SEQ perform transfers.
  - IDLE and BUSY produce an OKAY response and no memory access.
- Writes:
  - Committed at edge k+2 into the selected slave at the latched word index, with byte lanes chosen by hsize and haddr[1:0].
  - Byte: lane haddr[1:0], data taken from hwdata bits of that lane.
  - Halfword: lanes {haddr[1],0} and {haddr[1],1}.
  - Word: all lanes; haddr[1:0] ignored.
  - Unaligned sizes use the aligned lane rule, with no error.
- Reads:
  - The selected slave drives the full 32-bit word combinationally during the data phase.
  - The mux selects it by the latched hsel; out_hrdata is registered at edge k+2.
  - Read latency: inputs sampled at edge k give valid out_hrdata after edge k+2.
  - out_hrdata holds its value when no read completes.
- Default slave (hsel=3):
  - Writes ignored; reads return 0.
  - Response is ERROR for NONSEQ/SEQ, OKAY otherwise; hresp is internal only.
- hready is always 1 (no wait states). Back-to-back transfers are allowed every cycle.
- Write followed immediately by a read of the same address: the read sees the new data, because the write commits at the edge where the read's data phase begins.
- Index wrap: addresses beyond MEM_DEPTH words alias modulo MEM_DEPTH; the upper address bits are ignored.
- in_hburst has no effect on addressing; the requester supplies every beat address.

Test Plan:
- Reset: hresetn=1 for 2 cycles, then release -> out_hrdata=0; a read of slave 0, addr 0 returns 0.
- Single write then read: hsel=0, NONSEQ, word write addr 4, data 0xDEADBEEF; next cycle read addr 4 -> out_hrdata=0xDEADBEEF exactly 2 edges after the read address is sampled.
- Byte lanes: word write 0 to addr 0, byte write addr 1 data 0x0000AB00, then read addr 0 -> 0x0000AB00; halfword write addr 2 data 0x12340000 -> read 0x1234AB00.
- Slave isolation: write 0x11 to slave 0 addr 8 and 0x22 to slave 2 addr 8 -> reads return 0x11 and 0x22 respectively; slave 1 addr 8 returns 0.
- Qualifiers: enable=0 or htrans=IDLE/BUSY with a write of 0x55 -> memory unchanged and out_hrdata unchanged; hsel=3 read -> 0.
- Reset mid-write: assert hresetn during the data phase of a write of 0x99 -> the word reads back 0.
